// File: rtl/avalon_reg_fifo.sv
// avalon_reg_fifo: register-mapped FIFO peripheral behind the Avalon register adapter.
// Slot map: 0 DATA, 1 STATUS, 2 CONTROL, 3 THRESHOLD.
// Optional feature macro: AVALON_REG_FIFO_IRQ_EN adds the THRESHOLD register,
// the IRQ_PEND status bit and the irq output.
module avalon_reg_fifo #(
  parameter  int BUSWIDTH = 32,
  parameter  int DEPTH    = 16,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [3:0]               reg_write_en,
  input  logic [3:0]               reg_read_en,
  input  logic [BUSWIDTH-1:0]      reg_data_in,
  output logic [3:0][BUSWIDTH-1:0] reg_data_out
`ifdef AVALON_REG_FIFO_IRQ_EN
  ,
  output logic                     irq
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [BUSWIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [CW-1:0]       r_count;
  logic [BUSWIDTH-1:0] r_rd_hold;
  logic                r_ovf;
  logic                r_udf;
  logic                r_drop_oldest;

  logic                w_empty;
  logic                w_full;
  logic                w_clear;
  logic                w_push_req;
  logic                w_pop_req;
  logic                w_pop_ok;
  logic                w_push_ok;
  logic                w_ovf_set;
  logic                w_udf_set;
  logic                w_overwrite;
  logic                w_inc;
  logic                w_dec;
  logic                w_irq_pend;
  logic [BUSWIDTH-1:0] w_status;
  logic [BUSWIDTH-1:0] w_thr_rd;
  logic                w_unused;

  assign w_empty = (r_count == CW'(0));
  assign w_full  = (r_count == CW'(DEPTH));

  // CLEAR beats any same-cycle DATA access: the access is silently dropped.
  assign w_clear    = reg_write_en[2] & reg_data_in[0];
  assign w_push_req = reg_write_en[0] & ~w_clear;
  assign w_pop_req  = reg_read_en[0] & ~w_clear;

  // A pop on empty is an underflow; a push on full is only an overflow when
  // no pop frees a slot in the same cycle.
  assign w_pop_ok    = w_pop_req & ~w_empty;
  assign w_udf_set   = w_pop_req & w_empty;
  assign w_ovf_set   = w_push_req & w_full & ~w_pop_ok;
  assign w_overwrite = w_ovf_set & r_drop_oldest;
  assign w_push_ok   = w_push_req & (~w_full | w_pop_ok | r_drop_oldest);

  // An overwrite pushes and advances the head at once, so occupancy holds.
  assign w_inc = w_push_ok & ~w_pop_ok & ~w_overwrite;
  assign w_dec = w_pop_ok & ~w_push_ok;

  // Strobes of slots that have no side effect on read, kept out of the lint report.
  assign w_unused = &{1'b0, reg_read_en[3:1], reg_write_en[3]};

  // FIFO storage: plain array with no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= reg_data_in;
    end
  end

  // Pointers, occupancy, read holding register, sticky flags and control bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_rd_hold     <= '0;
      r_ovf         <= 1'b0;
      r_udf         <= 1'b0;
      r_drop_oldest <= 1'b0;
    end else begin
      if (w_clear) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push_ok) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        if (w_pop_ok || w_overwrite) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        if (w_inc) begin
          r_count <= r_count + CW'(1);
        end else if (w_dec) begin
          r_count <= r_count - CW'(1);
        end
      end
      if (w_pop_ok) begin
        r_rd_hold <= r_mem[r_rd_ptr];
      end
      // A new event in the same cycle as its write-1-to-clear keeps the flag set.
      r_ovf <= (r_ovf & ~(reg_write_en[1] & reg_data_in[2])) | w_ovf_set;
      r_udf <= (r_udf & ~(reg_write_en[1] & reg_data_in[3])) | w_udf_set;
      if (reg_write_en[2]) begin
        r_drop_oldest <= reg_data_in[1];
      end
    end
  end

`ifdef AVALON_REG_FIFO_IRQ_EN
  logic [CW-1:0] r_threshold;
  logic          r_irq_pend;

  // Threshold register and the registered level-interrupt condition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_threshold <= '0;
      r_irq_pend  <= 1'b0;
    end else begin
      if (reg_write_en[3]) begin
        r_threshold <= reg_data_in[CW-1:0];
      end
      r_irq_pend <= (r_threshold != CW'(0)) && (r_count >= r_threshold);
    end
  end

  assign w_irq_pend = r_irq_pend;
  assign irq        = r_irq_pend;
  assign w_thr_rd   = BUSWIDTH'(r_threshold);
`else
  assign w_irq_pend = 1'b0;
  assign w_thr_rd   = '0;
`endif

  // Read words are assembled purely from registered state.
  always_comb begin
    w_status         = '0;
    w_status[0]      = w_empty;
    w_status[1]      = w_full;
    w_status[2]      = r_ovf;
    w_status[3]      = r_udf;
    w_status[4]      = w_irq_pend;
    w_status[8 +: CW] = r_count;

    reg_data_out       = '0;
    reg_data_out[0]    = r_rd_hold;
    reg_data_out[1]    = w_status;
    reg_data_out[2][1] = r_drop_oldest;
    reg_data_out[3]    = w_thr_rd;
  end

endmodule
